instr_encoder: RTL

- Inverse of the instruction field decoder: takes decoded ARM-style fields and assembles the 32-bit instruction word.
- Used by the self-test/boot sequencer and the testbench program generator to build instruction memory contents.
- Data-processing constants are given as a raw 32-bit value. The block searches iteratively, one rotation per cycle, for a legal imm8/rot pair.
- Valid/ready handshake on both sides; one instruction in flight at a time.

---
 rtl/isa_pkg.sv | 79 +++++++
 rtl/imm_rot_check.sv | 21 ++
 rtl/instr_encoder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction encoder and decoder: kind codes,
// opcode classes, field positions and the word-assembly helpers.
package isa_pkg;

    localparam int ROT_STEPS = 16;
    localparam int ROT_W     = 4;

    typedef enum logic [1:0] {
        KIND_DPREG = 2'd0,
        KIND_DPIMM = 2'd1,
        KIND_MEM   = 2'd2,
        KIND_BR    = 2'd3
    } kind_e;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    // Field LSB positions; the decoder slices the word with the same constants.
    localparam int COND_LSB  = 28;
    localparam int OP_LSB    = 26;
    localparam int I_BIT     = 25;
    localparam int CMD_LSB   = 21;
    localparam int S_BIT     = 20;
    localparam int RN_LSB    = 16;
    localparam int RD_LSB    = 12;
    localparam int ROT_LSB   = 8;
    localparam int SHAMT_LSB = 7;
    localparam int SH_LSB    = 5;
    localparam int P_BIT     = 24;
    localparam int U_BIT     = 23;
    localparam int B_BIT     = 22;
    localparam int W_BIT     = 21;
    localparam int L_BIT     = 20;
    localparam int LINK_BIT  = 24;

    typedef struct packed {
        logic [3:0]  cond;
        logic [3:0]  cmd;
        logic        s;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [3:0]  rm;
        logic [1:0]  sh;
        logic [4:0]  shamt5;
        logic [31:0] imm32;
        logic [11:0] imm12;
        logic        mem_u;
        logic        mem_b;
        logic        mem_l;
        logic        br_link;
        logic [23:0] imm24;
    } req_t;

    function automatic logic [31:0] enc_dpreg(input req_t r);
        return {r.cond, OP_DP, 1'b0, r.cmd, r.s, r.rn, r.rd, r.shamt5, r.sh, 1'b0, r.rm};
    endfunction

    function automatic logic [31:0] enc_dpimm(input req_t r, input logic [ROT_W-1:0] rot,
                                              input logic [7:0] imm8);
        return {r.cond, OP_DP, 1'b1, r.cmd, r.s, r.rn, r.rd, rot, imm8};
    endfunction

    // Pre-indexed (P=1) without write-back (W=0) is the only addressing form emitted.
    function automatic logic [31:0] enc_mem(input req_t r);
        return {r.cond, OP_MEM, 1'b0, 1'b1, r.mem_u, r.mem_b, 1'b0, r.mem_l, r.rn, r.rd, r.imm12};
    endfunction

    function automatic logic [31:0] enc_br(input req_t r);
        return {r.cond, OP_BR, 1'b1, r.br_link, r.imm24};
    endfunction

endpackage

// File: rtl/imm_rot_check.sv
// Tests one rotation candidate: rotates the constant left by 2*rot and reports
// whether the result fits in an 8-bit immediate.
module imm_rot_check
    import isa_pkg::*;
(
    input  logic [31:0]      imm32,
    input  logic [ROT_W-1:0] rot,
    output logic [7:0]       cand,
    output logic             fits
);

    logic [4:0]  amt;
    logic [31:0] rotated;

    assign amt = {rot, 1'b0};
    // A shift by 32 yields zero, so amt=0 degenerates cleanly to the identity.
    assign rotated = (imm32 << amt) | (imm32 >> (6'd32 - {1'b0, amt}));
    assign cand    = rotated[7:0];
    assign fits    = (rotated[31:8] == 24'd0);

endmodule

// File: rtl/instr_encoder.sv
// Assembles 32-bit ARM-style instruction words from decoded fields; DP
// immediates are encoded by a one-rotation-per-cycle search.
module instr_encoder
    import isa_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  kind,
    input  logic [3:0]  cond,
    input  logic [3:0]  cmd,
    input  logic        s,
    input  logic [3:0]  rn,
    input  logic [3:0]  rd,
    input  logic [3:0]  rm,
    input  logic [1:0]  sh,
    input  logic [4:0]  shamt5,
    input  logic [31:0] imm32,
    input  logic [11:0] imm12,
    input  logic        mem_u,
    input  logic        mem_b,
    input  logic        mem_l,
    input  logic        br_link,
    input  logic [23:0] imm24,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr_out,
    output logic        out_err
);

    state_e           state, state_nxt;
    logic [ROT_W-1:0] rot_cnt, rot_nxt;
    req_t             req, req_in;
    logic [31:0]      instr_nxt;
    logic             err_nxt;
    logic             load_req;
    logic [7:0]       cand;
    logic             fits;

    always_comb begin
        req_in.cond    = cond;
        req_in.cmd     = cmd;
        req_in.s       = s;
        req_in.rn      = rn;
        req_in.rd      = rd;
        req_in.rm      = rm;
        req_in.sh      = sh;
        req_in.shamt5  = shamt5;
        req_in.imm32   = imm32;
        req_in.imm12   = imm12;
        req_in.mem_u   = mem_u;
        req_in.mem_b   = mem_b;
        req_in.mem_l   = mem_l;
        req_in.br_link = br_link;
        req_in.imm24   = imm24;
    end

    imm_rot_check u_rot_check (
        .imm32 (req.imm32),
        .rot   (rot_cnt),
        .cand  (cand),
        .fits  (fits)
    );

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt = state;
        rot_nxt   = rot_cnt;
        instr_nxt = instr_out;
        err_nxt   = out_err;
        load_req  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (in_valid) begin
                    load_req = 1'b1;
                    rot_nxt  = '0;
                    unique case (kind_e'(kind))
                        KIND_DPREG: begin
                            instr_nxt = enc_dpreg(req_in);
                            err_nxt   = 1'b0;
                            state_nxt = S_DONE;
                        end
                        KIND_DPIMM: state_nxt = S_SEARCH;
                        KIND_MEM: begin
                            instr_nxt = enc_mem(req_in);
                            err_nxt   = 1'b0;
                            state_nxt = S_DONE;
                        end
                        KIND_BR: begin
                            instr_nxt = enc_br(req_in);
                            err_nxt   = 1'b0;
                            state_nxt = S_DONE;
                        end
                    endcase
                end
            end
            S_SEARCH: begin
                if (fits) begin
                    instr_nxt = enc_dpimm(req, rot_cnt, cand);
                    err_nxt   = 1'b0;
                    state_nxt = S_DONE;
                end else if (rot_cnt == ROT_W'(ROT_STEPS - 1)) begin
                    instr_nxt = '0;
                    err_nxt   = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    rot_nxt = rot_cnt + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // The latched request is cleared on reset too, so an aborted search leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rot_cnt   <= '0;
            req       <= '0;
            instr_out <= '0;
            out_err   <= 1'b0;
        end else begin
            rot_cnt   <= rot_nxt;
            instr_out <= instr_nxt;
            out_err   <= err_nxt;
            if (load_req) req <= req_in;
        end
    end

endmodule
